// File: rtl/serial_adder_arbiter_if.sv
// Requester-side bundle for the shared bit-serial adder: requests, packed operands,
// grant/done handshake and the returned result.
interface serial_adder_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       cin;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      sum;
    logic                  cout;
    logic [IDW-1:0]        owner;

    modport master (
        output req, a_in, b_in, cin,
        input  gnt, busy, done, sum, cout, owner
    );

    modport slave (
        input  req, a_in, b_in, cin,
        output gnt, busy, done, sum, cout, owner
    );
endinterface

// File: rtl/serial_adder_arbiter.sv
// Round-robin arbiter in front of a single full-adder slice plus carry flop; the winner's
// operands are added LSB-first over WIDTH cycles and returned with its owner ID.
module serial_adder_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input logic                  CLK,
    input logic                  RESET,
    serial_adder_arbiter_if.slave bus
);
    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             carry;
    logic [CNTW-1:0]  count;
    logic [IDW-1:0]   ptr, winner;
    logic             found, start, last;
    logic             bit_s, bit_c;
    logic [NREQ-1:0]  gnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [IDW-1:0]   owner_q;
    int               idx;

    assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last  = (count == CNTW'(WIDTH - 1));

    // Scan starts just after the previous winner, so that winner drops to lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            carry   <= 1'b0;
            count   <= '0;
            ptr     <= IDW'(NREQ - 1);
            gnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            owner_q <= '0;
        end else begin
            gnt_q <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= bus.a_in[winner*WIDTH +: WIDTH];
                        b_sh  <= bus.b_in[winner*WIDTH +: WIDTH];
                        carry <= bus.cin[winner];
                        count <= '0;
                        ptr   <= winner;
                        gnt_q <= NREQ'(1) << winner;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= bit_c;
                    s_sh  <= {bit_s, s_sh[WIDTH-1:1]};
                    count <= count + CNTW'(1);
                    if (last) begin
                        sum_q   <= {bit_s, s_sh[WIDTH-1:1]};
                        cout_q  <= bit_c;
                        owner_q <= ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.owner = owner_q;
endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Scoreboard bench for serial_adder_arbiter: directed requests push expected grants and
// results; a negedge monitor pops and compares whenever gnt or done appears.
module tb_serial_adder_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [IDW-1:0]   owner;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } res_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    serial_adder_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    serial_adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    res_t            expRes[$];
    logic [NREQ-1:0] expGnt[$];
    int              nChecks = 0;
    int              nPass = 0;
    int              cycleCnt = 0;
    int              busyCount = 0;
    int              gntCount = 0;
    int              doneCount = 0;
    int              lastGntCycle = 0;
    int              lastDoneCycle = 0;
    int              issueCycle = 0;
    logic            prevDone = 1'b0;
    res_t            monRes;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge CLK) cycleCnt++;

    // Monitor: every grant and every done must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (bus.busy === 1'b1) busyCount++;
        if (bus.gnt !== '0 && bus.gnt !== 'x) begin
            gntCount++;
            lastGntCycle = cycleCnt;
            if (expGnt.size() == 0) checkOutput("unexpected_gnt", 32'(bus.gnt), 32'(0));
            else checkOutput("gnt", 32'(bus.gnt), 32'(expGnt.pop_front()));
        end
        if (bus.done === 1'b1) begin
            doneCount++;
            lastDoneCycle = cycleCnt;
            checkOutput("done_pulse_width", 32'(prevDone), 32'(0));
            if (expRes.size() == 0) begin
                checkOutput("unexpected_done", 32'(1), 32'(0));
            end else begin
                monRes = expRes.pop_front();
                checkOutput("sum", 32'(bus.sum), 32'(monRes.sum));
                checkOutput("cout", 32'(bus.cout), 32'(monRes.cout));
                checkOutput("owner", 32'(bus.owner), 32'(monRes.owner));
            end
        end
        prevDone = (bus.done === 1'b1);
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_gnt"}, 32'(bus.gnt), 32'(0));
        checkOutput({tag, "_done"}, 32'(bus.done), 32'(0));
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(0));
        checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(0));
        checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(0));
        checkOutput({tag, "_owner"}, 32'(bus.owner), 32'(0));
    endtask

    task automatic waitGnt(input int win);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (bus.gnt[win] === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("gnt_timeout", 32'(0), 32'(1));
    endtask

    task automatic waitIdle();
        bit idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge CLK);
            if (expRes.size() == 0 && bus.busy === 1'b0) idle = 1'b1;
        end
        if (!idle) checkOutput("idle_timeout", 32'(0), 32'(1));
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int win,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic [WIDTH-1:0] expSum,
                                 input logic expCout, input bit expectDone);
        res_t r;
        @(posedge CLK);
        #1;
        bus.a_in[win*WIDTH +: WIDTH] = a;
        bus.b_in[win*WIDTH +: WIDTH] = b;
        bus.cin[win] = c;
        bus.req = mask;
        issueCycle = cycleCnt + 1;
        expGnt.push_back(NREQ'(1) << win);
        if (expectDone) begin
            r.owner = IDW'(win);
            r.sum   = expSum;
            r.cout  = expCout;
            expRes.push_back(r);
        end
        waitGnt(win);
        @(posedge CLK);
        #1;
        bus.req = '0;
    endtask

    logic [WIDTH-1:0] rrA[NREQ]   = '{8'h10, 8'h80, 8'hAA, 8'h7F};
    logic [WIDTH-1:0] rrB[NREQ]   = '{8'h20, 8'h80, 8'h55, 8'h01};
    logic             rrC[NREQ]   = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [WIDTH-1:0] rrSum[NREQ] = '{8'h30, 8'h01, 8'h00, 8'h80};
    logic             rrCo[NREQ]  = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int busyBefore, doneBefore, gntBefore, prevGnt, wi;
        res_t r;
        bit seen;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.cin  = '0;

        // Reset held with random requests, then released with no requests.
        for (int i = 0; i < 3; i++) begin
            bus.req = NREQ'($urandom);
            @(negedge CLK);
            checkIdle("reset");
        end
        @(posedge CLK);
        #1;
        bus.req = '0;
        RESET   = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            checkIdle("post_reset");
        end

        $display("[TB] single request, latency and busy length");
        busyBefore = busyCount;
        applyStimulus(4'b0100, 2, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        waitIdle();
        checkOutput("gnt_latency", 32'(lastGntCycle - issueCycle), 32'(0));
        checkOutput("done_latency", 32'(lastDoneCycle - issueCycle), 32'(WIDTH));
        checkOutput("busy_cycles", 32'(busyCount - busyBefore), 32'(WIDTH + 1));

        $display("[TB] carry boundaries");
        applyStimulus(4'b0001, 0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(4'b0001, 0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1);
        waitIdle();

        $display("[TB] round robin with all requests held");
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(negedge CLK);
        checkIdle("pre_rr");
        for (int i = 0; i < NREQ; i++) begin
            bus.a_in[i*WIDTH +: WIDTH] = rrA[i];
            bus.b_in[i*WIDTH +: WIDTH] = rrB[i];
            bus.cin[i] = rrC[i];
        end
        for (int k = 0; k < 5; k++) begin
            wi = k % NREQ;
            expGnt.push_back(NREQ'(1) << wi);
            r.owner = IDW'(wi);
            r.sum   = rrSum[wi];
            r.cout  = rrCo[wi];
            expRes.push_back(r);
        end
        @(posedge CLK);
        #1;
        bus.req = 4'b1111;
        prevGnt = 0;
        for (int k = 0; k < 5; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge CLK);
                if (bus.gnt !== '0) seen = 1'b1;
            end
            if (!seen) checkOutput("rr_gnt_timeout", 32'(0), 32'(1));
            if (k > 0) checkOutput("rr_period", 32'(cycleCnt - prevGnt), 32'(WIDTH + 2));
            prevGnt = cycleCnt;
        end
        @(posedge CLK);
        #1;
        bus.req = '0;
        waitIdle();

        $display("[TB] reset in the middle of a shift");
        applyStimulus(4'b1000, 3, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(negedge CLK);
        checkIdle("abort");
        bus.a_in[3*WIDTH +: WIDTH] = 8'hEE;
        applyStimulus(4'b1010, 1, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b1);
        waitIdle();

        $display("[TB] request pulsed only while another operation shifts");
        doneBefore = doneCount;
        gntBefore  = gntCount;
        applyStimulus(4'b0100, 2, 8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b1);
        bus.req[0] = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        bus.req[0] = 1'b0;
        waitIdle();
        repeat (15) @(negedge CLK);
        checkOutput("pulsed_done_count", 32'(doneCount - doneBefore), 32'(1));
        checkOutput("pulsed_gnt_count", 32'(gntCount - gntBefore), 32'(1));
        checkOutput("leftover_gnt", 32'(expGnt.size()), 32'(0));
        checkOutput("leftover_res", 32'(expRes.size()), 32'(0));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
